// File: rtl/shift_sequencer_if.sv
// Bundles the two producer handshakes, the shift-register pins and the status
// outputs of shift_sequencer. The sequencer uses the slave view.
interface shift_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             sr_data_in;
    logic             sr_shift_enable;
    logic [WIDTH-1:0] sr_data_out;
    logic             busy;
    logic             grant_id;
    logic             done;
    logic [WIDTH-1:0] result;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, sr_data_out,
        output req0_ready, req1_ready, sr_data_in, sr_shift_enable,
               busy, grant_id, done, result
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, sr_data_out,
        input  req0_ready, req1_ready, sr_data_in, sr_shift_enable,
               busy, grant_id, done, result
    );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin owner of an 8-bit SIPO shift register: accepts a word from one of
// two producers, shifts it in MSB-first, then returns the register contents.
module shift_sequencer #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              reset_n,
    shift_sequencer_if.slave bus
);

    localparam int                CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CAPTURE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             sr_en_q, sr_en_d;
    logic             sr_din_q, sr_din_d;
    logic             done_q, done_d;
    logic             grant0, grant1;

    // Readies are gated by reset so nothing looks accepted while held in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && reset_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        result_d     = result_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        sr_en_d      = sr_en_q;
        sr_din_d     = sr_din_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    word_d       = grant1 ? bus.req1_data : bus.req0_data;
                    grant_id_d   = grant1;
                    last_grant_d = grant1;
                    count_d      = '0;
                    sr_en_d      = 1'b1;
                    sr_din_d     = word_d[WIDTH-1];
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                // sr_din is registered, so it is loaded one bit ahead of the shift.
                count_d = count_q + 1'b1;
                word_d  = word_q << 1;
                if (count_q == LAST_COUNT) begin
                    sr_en_d  = 1'b0;
                    sr_din_d = 1'b0;
                    state_d  = CAPTURE;
                end else begin
                    sr_din_d = word_q[WIDTH-2];
                end
            end
            CAPTURE: begin
                result_d = bus.sr_data_out;
                done_d   = 1'b1;
                sr_en_d  = 1'b0;
                sr_din_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            word_q       <= '0;
            result_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            sr_en_q      <= 1'b0;
            sr_din_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            result_q     <= result_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            sr_en_q      <= sr_en_d;
            sr_din_q     <= sr_din_d;
            done_q       <= done_d;
        end
    end

    assign bus.req0_ready      = grant0;
    assign bus.req1_ready      = grant1;
    assign bus.sr_data_in      = sr_din_q;
    assign bus.sr_shift_enable = sr_en_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.grant_id        = grant_id_q;
    assign bus.done            = done_q;
    assign bus.result          = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a cycle-offset transfer model plus a behavioural
// SIPO register, directed scenarios and a randomized traffic phase.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(WIDTH)) bus ();

    shift_sequencer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stand-in for the shift_register instance: shifts left, new bit at LSB.
    logic [WIDTH-1:0] sr_q;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sr_q <= '0;
        else if (bus.sr_shift_enable)
            sr_q <= {sr_q[WIDTH-2:0], bus.sr_data_in};
    end
    assign bus.sr_data_out = sr_q;

    // Reference: m_cyc counts edges since acceptance; everything follows from it.
    bit               m_active;
    int               m_cyc;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] m_result;
    bit               m_grant;
    bit               m_last;
    bit               m_idle;
    bit               m_g;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_cyc    = 0;
            m_word   = '0;
            m_result = '0;
            m_grant  = 1'b0;
            m_last   = 1'b1;
        end else begin
            m_idle = !m_active || (m_cyc >= LAT);
            if (m_active) begin
                m_cyc = m_cyc + 1;
                if (m_cyc == LAT) m_result = m_word;
                if (m_cyc > LAT) m_active = 1'b0;
            end
            if (m_idle && (bus.req0_valid || bus.req1_valid)) begin
                m_g      = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
                m_word   = m_g ? bus.req1_data : bus.req0_data;
                m_grant  = m_g;
                m_last   = m_g;
                m_active = 1'b1;
                m_cyc    = 1;
            end
        end
    end

    int               tests = 0;
    int               fails = 0;
    int               cyc_no = 0;
    int               lo_run = 0;
    bit               seen_hi = 1'b0;
    int               done_cyc_q[$];
    logic [WIDTH-1:0] done_res_q[$];
    bit               done_gid_q[$];
    int               acc_cyc_q[$];
    bit               acc_id_q[$];
    bit               bits_q[$];
    int               gap_q[$];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_all();
        bit e_en, e_din, e_busy, e_done, e_r0, e_r1;
        e_en   = m_active && m_cyc >= 1 && m_cyc <= WIDTH;
        e_din  = e_en ? m_word[WIDTH-m_cyc] : 1'b0;
        e_busy = m_active && m_cyc >= 1 && m_cyc <= WIDTH + 1;
        e_done = m_active && m_cyc == LAT;
        e_r0   = reset_n && !e_busy && bus.req0_valid && (!bus.req1_valid || m_last);
        e_r1   = reset_n && !e_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
        check_output("shift_enable", bus.sr_shift_enable, e_en);
        check_output("data_in", bus.sr_data_in, e_din);
        check_output("busy", bus.busy, e_busy);
        check_output("done", bus.done, e_done);
        check_output("result", bus.result, m_result);
        check_output("grant_id", bus.grant_id, m_grant);
        check_output("req0_ready", bus.req0_ready, e_r0);
        check_output("req1_ready", bus.req1_ready, e_r1);
        if (m_active && m_cyc == WIDTH + 1)
            check_output("capture_sr", sr_q, m_word);

        cyc_no++;
        if (bus.done) begin
            done_cyc_q.push_back(cyc_no);
            done_res_q.push_back(bus.result);
            done_gid_q.push_back(bus.grant_id);
        end
        if (bus.req0_valid && bus.req0_ready) begin
            acc_cyc_q.push_back(cyc_no);
            acc_id_q.push_back(1'b0);
        end
        if (bus.req1_valid && bus.req1_ready) begin
            acc_cyc_q.push_back(cyc_no);
            acc_id_q.push_back(1'b1);
        end
        if (bus.sr_shift_enable) begin
            bits_q.push_back(bus.sr_data_in);
            if (seen_hi && lo_run > 0) gap_q.push_back(lo_run);
            lo_run  = 0;
            seen_hi = 1'b1;
        end else if (seen_hi) begin
            lo_run++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accepts(input int target, input int max_cyc, input string name);
        int k = 0;
        while (acc_id_q.size() < target && k < max_cyc) begin
            tick();
            k++;
        end
        check_output({name, "_accepts"}, acc_id_q.size(), target);
    endtask

    task automatic wait_dones(input int target, input int max_cyc, input string name);
        int k = 0;
        while (done_cyc_q.size() < target && k < max_cyc) begin
            tick();
            k++;
        end
        check_output({name, "_dones"}, done_cyc_q.size(), target);
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_en"}, bus.sr_shift_enable, 0);
        check_output({name, "_din"}, bus.sr_data_in, 0);
        check_output({name, "_busy"}, bus.busy, 0);
        check_output({name, "_done"}, bus.done, 0);
        check_output({name, "_grant"}, bus.grant_id, 0);
        check_output({name, "_result"}, bus.result, 0);
        check_output({name, "_ready0"}, bus.req0_ready, 0);
        check_output({name, "_ready1"}, bus.req1_ready, 0);
    endtask

    task automatic apply_stimulus(input bit v0, input logic [WIDTH-1:0] d0,
                                  input bit v1, input logic [WIDTH-1:0] d1);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
    endtask

    initial begin
        int               nb, nd, na;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] lone_words [2];
        lone_words[0] = 8'hC3;
        lone_words[1] = 8'h3C;

        // Reset held with both producers requesting.
        apply_stimulus(1'b1, 8'h11, 1'b1, 8'h22);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check_output("reset_first_ready0", bus.req0_ready, 1);
        check_output("reset_first_ready1", bus.req1_ready, 0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        tick();

        // Single request from requester 0.
        nb = bits_q.size();
        nd = done_cyc_q.size();
        na = acc_id_q.size();
        apply_stimulus(1'b1, 8'hA5, 1'b0, 8'h00);
        wait_accepts(na + 1, 4, "single");
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        wait_dones(nd + 1, 20, "single");
        w = '0;
        for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], bits_q[nb+i]};
        check_output("single_bits", w, 8'hA5);
        check_output("single_en_cycles", bits_q.size() - nb, 8);
        check_output("single_latency", done_cyc_q[nd] - acc_cyc_q[na], 10);
        check_output("single_result", done_res_q[nd], 8'hA5);
        check_output("single_grant", done_gid_q[nd], 0);

        // Requester 1 alone, twice in a row.
        for (int i = 0; i < 2; i++) begin
            nd = done_cyc_q.size();
            na = acc_id_q.size();
            apply_stimulus(1'b0, 8'h00, 1'b1, lone_words[i]);
            wait_accepts(na + 1, 4, "lone");
            apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
            wait_dones(nd + 1, 20, "lone");
            check_output("lone_accept_id", acc_id_q[na], 1);
            check_output("lone_grant", done_gid_q[nd], 1);
            check_output("lone_result", done_res_q[nd], lone_words[i]);
        end

        // Contention: both held for four transfers.
        nd = done_cyc_q.size();
        na = acc_id_q.size();
        apply_stimulus(1'b1, 8'h0F, 1'b1, 8'hF0);
        wait_accepts(na + 4, 60, "rr");
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        wait_dones(nd + 4, 20, "rr");
        for (int i = 0; i < 4; i++) begin
            check_output("rr_accept_id", acc_id_q[na+i], i % 2);
            check_output("rr_grant", done_gid_q[nd+i], i % 2);
            check_output("rr_result", done_res_q[nd+i], (i % 2) ? 8'hF0 : 8'h0F);
            if (i > 0)
                check_output("rr_spacing", done_cyc_q[nd+i] - done_cyc_q[nd+i-1], 10);
        end

        // Reset after the fourth shift of 0xFF.
        na = acc_id_q.size();
        apply_stimulus(1'b1, 8'hFF, 1'b0, 8'h00);
        wait_accepts(na + 1, 4, "midrst");
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        nd = done_cyc_q.size();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        check_output("midrst_no_done", done_cyc_q.size(), nd);
        na = acc_id_q.size();
        apply_stimulus(1'b1, 8'h81, 1'b1, 8'h7E);
        wait_accepts(na + 1, 4, "midrst_after");
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        wait_dones(nd + 1, 20, "midrst_after");
        check_output("midrst_tie_to_0", acc_id_q[na], 0);
        check_output("midrst_result", done_res_q[nd], 8'h81);

        // Back-to-back from requester 0.
        nd = done_cyc_q.size();
        na = acc_id_q.size();
        apply_stimulus(1'b1, 8'h55, 1'b0, 8'h00);
        wait_accepts(na + 1, 4, "b2b_first");
        apply_stimulus(1'b1, 8'hAA, 1'b0, 8'h00);
        wait_accepts(na + 2, 20, "b2b_second");
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        wait_dones(nd + 2, 20, "b2b");
        check_output("b2b_accept_in_done", acc_cyc_q[na+1], done_cyc_q[nd]);
        check_output("b2b_gap", gap_q[gap_q.size()-1], 2);
        check_output("b2b_result0", done_res_q[nd], 8'h55);
        check_output("b2b_result1", done_res_q[nd+1], 8'hAA);

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus($urandom_range(0, 9) < 6, WIDTH'($urandom),
                           $urandom_range(0, 9) < 6, WIDTH'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                #2 reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick();
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Two-requester controller that owns the 8-bit serial-in/parallel-out `shift_register` and shares it between two parallel-word producers. It grants one requester at a time with round-robin arbitration and serializes the accepted word MSB-first onto the register's `data_in`/`shift_enable` pins. After the last shift it samples the register's parallel `data_out` and returns it with a one-cycle `done` pulse. It sits between the producer logic and the `shift_register` instance and is the only driver of that instance's data and enable inputs.

## Interface
- `WIDTH`, default 8: word width; must equal the shift register width. Shift count is `WIDTH`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  WIDTH  requester 0 word; sampled only at acceptance.
- `req0_ready`  out  1  requester 0 word accepted this edge if `req0_valid`.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `sr_data_in`  out  1  serial bit to `shift_register.data_in`.
- `sr_shift_enable`  out  1  to `shift_register.shift_enable`.
- `sr_data_out`  in  WIDTH  from `shift_register.data_out`.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  1  requester owning the current or most recent transfer.
- `done`  out  1  one-cycle pulse; `result` is valid while `done` is high.
- `result`  out  WIDTH  captured `sr_data_out`; held until the next `done`.

## Operation
- FSM states: IDLE, SHIFT, CAPTURE.
- **IDLE**
  - Arbitration is combinational from both valids and the registered `last_grant`.
  - Only one valid: that requester is granted.
  - Both valid: grant goes to `!last_grant`.
  - `reqN_ready = idle && granted(N)`. At most one ready is high, and ready is never high without its valid.
  - Producers must not make valid depend on ready.
  - Acceptance (`valid && ready` at an edge) does the following:
    - load `reqN_data` into the internal word register;
    - set `grant_id` and `last_grant` to N;
    - clear the bit counter;
    - move to SHIFT.
- **SHIFT**
  - Registered outputs: `sr_shift_enable` = 1 and `sr_data_in` = word[WIDTH-1].
  - Each edge shifts the word left by one and increments the counter.
  - After `WIDTH` cycles, move to CAPTURE.
- **CAPTURE**
  - `sr_shift_enable` = 0 and `sr_data_in` = 0.
  - At the exiting edge: `result <= sr_data_out`, `done <= 1`, state <= IDLE.
- `done` is high for exactly the first IDLE cycle after CAPTURE. A new acceptance may occur in that same cycle.
- Counter width is `$clog2(WIDTH+1)`. The counter wraps only through reload at acceptance.
- The block does not drive the shift register's reset. The system `reset_n` is shared, so the register starts at zero.

## Timing
- Acceptance edge is E0.
- Cycles E0+1 .. E0+WIDTH:
  - `sr_shift_enable` = 1;
  - `sr_data_in` = word bits WIDTH-1 down to 0, one per cycle;
  - the shift register samples each bit at the edge ending its cycle.
- Cycle E0+WIDTH+1: CAPTURE. `busy` = 1 and `sr_data_out` equals the accepted word.
- Cycle E0+WIDTH+2: `done` = 1, `result` = word, `busy` = 0.
- Latency from acceptance to `done` is WIDTH+2 cycles (10 for WIDTH = 8).
- Maximum throughput is one word per WIDTH+2 cycles. With back-to-back acceptances, `sr_shift_enable` is low for exactly 2 cycles between bursts.
- Reset values (applied asynchronously on `reset_n` low):
  - state = IDLE, `last_grant` = 1;
  - `sr_shift_enable`, `sr_data_in`, `busy`, `done`, `grant_id` = 0;
  - `result` = 0.
- Reset mid-SHIFT or mid-CAPTURE:
  - outputs return to their reset values immediately;
  - the transfer is discarded and no `done` is produced;
  - after release, the first tie goes to requester 0.
- Valid deasserted while not ready: no effect, no acceptance.

## Test plan
- **Reset:** drive `reset_n` = 0 with both valids high. All outputs must be 0 and both readies low. Release reset, then `req0_ready` = 1 in the first cycle.
- **Single request:** `req0` sends 0xA5. `sr_data_in` must read 1,0,1,0,0,1,0,1 over the 8 enabled cycles, and `sr_shift_enable` is high exactly 8 cycles. `done` fires 10 cycles after acceptance with `result` = 0xA5, `grant_id` = 0 (checked against a bound `shift_register`).
- **Round-robin contention:** both valid held, `req0` = 0x0F, `req1` = 0xF0. Grants must alternate 0,1,0,1, with `done` every 10 cycles and results 0x0F, 0xF0, 0x0F, 0xF0.
- **Lone requester:** only `req1` valid, 0x3C, after a `req1` transfer. `req1` is granted again, `result` = 0x3C, `grant_id` = 1.
- **Reset mid-shift:** assert reset after the 4th shift of 0xFF. Outputs clear asynchronously and no `done` is produced. After release, `req0` with 0x81 completes with `result` = 0x81.
- **Back-to-back:** `req0` valid held with 0x55, then 0xAA. The second acceptance occurs in the first `done` cycle, with exactly 2 non-enabled cycles between shift bursts and results 0x55 then 0xAA.
